serial_pattern_tx: RTL and testbench
====================================

Name: serial_pattern_tx

Overview:
Serial bit-pattern transmitter. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on a single-bit line. This is the stimulus end of the team's 00/11 pair-detector path: `outp` drives a detector's serial input. Between words it drives an alternating idle pattern, so idle cycles never form a 00/11 pair.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- GAP, 1, idle cycles inserted after each word; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset; sampled on the clk rising edge.
- inp  input  WIDTH  parallel word; sampled on accept.
- in_valid  input  1  upstream has a word on inp.
- in_ready  output  1  block can accept a word this cycle.
- outp  output  1  serial data or idle pattern.
- out_valid  output  1  outp carries a data bit.
- done  output  1  one-cycle pulse, coincident with the last data bit of a word.

Behaviour:
- Reset (rst==0 at a posedge):
  - state=IDLE, outp=0, out_valid=0, done=0, bit and gap counters cleared.
  - in_ready=1 from the first cycle after reset release.
  - Reset mid-word aborts the word; no done pulse is produced.
- Output registration:
  - outp, out_valid and done are registered.
  - in_ready is combinational from state/counters only, never from in_valid.
- States:
  - IDLE: in_ready=1; out_valid=0; outp toggles every cycle.
    - Accept (in_valid && in_ready): latch inp into the shift register, outp<=inp[WIDTH-1], out_valid<=1, bit_cnt<=WIDTH-1, go to SHIFT.
  - SHIFT: each edge drives the next lower bit on outp while bit_cnt decrements.
    - When bit_cnt==1, the edge drives bit 0 and asserts done for that cycle.
    - Exit when the cycle showing bit 0 ends:
      - GAP>0: go to GAP; out_valid<=0; outp<=~bit0.
      - GAP==0: in_ready=1 during the bit-0 cycle. An accept there loads the next word back-to-back with no invalid cycle; otherwise go to IDLE with outp<=~bit0.
  - GAP: out_valid=0, in_ready=0, outp toggles each cycle; after GAP cycles go to IDLE.
- Latency: first data bit is visible on outp immediately after the accept edge. A word occupies exactly WIDTH consecutive out_valid cycles.
- in_valid while in_ready=0: ignored. Upstream holds inp/in_valid until accepted.
- Counter widths: bit_cnt is $clog2(WIDTH) bits; gap_cnt is 4 bits. Counters never wrap; they saturate at terminal count.
- Guarantee: no equal adjacent pair crosses the data→idle boundary. The idle→data boundary may form a pair; that is permitted and excluded from exp_hits.

Optional Feature:
- Macro: SERIAL_PATTERN_TX_EXP_HITS_EN.
- With the macro:
  - Adds output port exp_hits, $clog2(WIDTH) bits.
  - exp_hits = number of overlapping equal adjacent bit pairs within the accepted word (WIDTH-1 comparisons).
  - Registered on the accept edge; held until the next accept; reset value 0.
  - Used by benches to predict detector hits.
- Without the macro: port and logic are absent.

Decomposition:
- Package serial_pattern_tx_pkg:
  - state typedef {IDLE, SHIFT, GAP}.
  - GAP_W=4.
  - Parameter legality constants.
- One sub-module, pair_count:
  - Combinational popcount of ~(w[WIDTH-1:1]^w[WIDTH-2:0]).
  - Instantiated only under the macro.

Test Plan (WIDTH=8):
- Reset: rst=0 for 2 cycles, then release → outp=0, out_valid=0, done=0; in_ready=1 on the first cycle after release.
- Single word, GAP=1: accept 8'b11001010 → outp 1,1,0,0,1,0,1,0 on 8 consecutive out_valid cycles; done only on the 8th; exp_hits=2.
- GAP timing, GAP=1: after the word above → one cycle with out_valid=0, outp=1, in_ready=0; then IDLE with in_ready=1 and outp toggling.
- Back-to-back, GAP=0: in_valid held with 8'hFF then 8'h00 → 16 contiguous out_valid cycles; done at cycles 8 and 16; exp_hits=7 after each accept.
- Reset mid-word: rst=0 after the 3rd data bit → next cycle out_valid=0, done never pulses; in_ready=1 after release.
- Ignored request, GAP=1: in_valid asserted throughout SHIFT → no accept until IDLE; the second word starts exactly 1 idle cycle after the first word's done.

Source files
------------

// File: rtl/serial_pattern_tx_pkg.sv
// rtl/serial_pattern_tx_pkg.sv - shared types and constants for the serial pattern transmitter
package serial_pattern_tx_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam int GAP_W     = 4;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
  localparam int GAP_MIN   = 0;
  localparam int GAP_MAX   = 15;

  function automatic bit params_ok(input int width, input int gap);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (gap >= GAP_MIN) && (gap <= GAP_MAX);
  endfunction

endpackage

// File: rtl/serial_pattern_tx_if.sv
// rtl/serial_pattern_tx_if.sv - word-in / bit-out bus of the transmitter
// SERIAL_PATTERN_TX_EXP_HITS_EN adds the exp_hits signal.
interface serial_pattern_tx_if #(parameter int WIDTH = 8);

  logic [WIDTH-1:0] inp;
  logic             in_valid;
  logic             in_ready;
  logic             outp;
  logic             out_valid;
  logic             done;

`ifdef SERIAL_PATTERN_TX_EXP_HITS_EN
  logic [$clog2(WIDTH)-1:0] exp_hits;

  modport master (output inp, in_valid, input in_ready, outp, out_valid, done, exp_hits);
  modport slave  (input inp, in_valid, output in_ready, outp, out_valid, done, exp_hits);
`else
  modport master (output inp, in_valid, input in_ready, outp, out_valid, done);
  modport slave  (input inp, in_valid, output in_ready, outp, out_valid, done);
`endif

endinterface

// File: rtl/serial_pattern_tx_pair_count.sv
// rtl/serial_pattern_tx_pair_count.sv - counts overlapping equal adjacent bit pairs in a word
module pair_count #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         w,
  output logic [$clog2(WIDTH)-1:0] count
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-2:0] eq;

  assign eq = ~(w[WIDTH-1:1] ^ w[WIDTH-2:0]);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      count = count + CW'(eq[i]);
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - MSB-first serial transmitter with alternating idle pattern
// SERIAL_PATTERN_TX_EXP_HITS_EN adds exp_hits (equal-pair count of the accepted word).
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input logic              clk,
  input logic              rst,
  serial_pattern_tx_if.slave bus
);

  localparam int BW = $clog2(WIDTH);

  if (!params_ok(WIDTH, GAP)) begin : g_bad_params
    $error("serial_pattern_tx: WIDTH or GAP out of range");
  end

  state_t            state, state_n;
  logic [WIDTH-2:0]  shreg, shreg_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
  logic              outp_q, outp_n;
  logic              out_valid_q, out_valid_n;
  logic              done_q, done_n;
  logic              in_ready;
  logic              accept;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      outp_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      bit_cnt     <= bit_cnt_n;
      gap_cnt     <= gap_cnt_n;
      outp_q      <= outp_n;
      out_valid_q <= out_valid_n;
      done_q      <= done_n;
    end
  end

  // Idle and gap cycles invert the previous bit, so leaving a word never forms a pair.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    bit_cnt_n   = bit_cnt;
    gap_cnt_n   = gap_cnt;
    outp_n      = ~outp_q;
    out_valid_n = 1'b0;
    done_n      = 1'b0;
    in_ready    = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        if (bit_cnt == '0) begin
          in_ready = (GAP == 0);
          if (GAP > 0) begin
            state_n   = serial_pattern_tx_pkg::GAP;
            gap_cnt_n = GAP_W'(GAP - 1);
          end else begin
            state_n = IDLE;
          end
        end else begin
          outp_n      = shreg[WIDTH-2];
          shreg_n     = shreg << 1;
          bit_cnt_n   = bit_cnt - BW'(1);
          out_valid_n = 1'b1;
          done_n      = (bit_cnt == BW'(1));
        end
      end
      serial_pattern_tx_pkg::GAP: begin
        if (gap_cnt == '0) begin
          state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    accept = bus.in_valid && in_ready;
    if (accept) begin
      state_n     = SHIFT;
      shreg_n     = bus.inp[WIDTH-2:0];
      outp_n      = bus.inp[WIDTH-1];
      bit_cnt_n   = BW'(WIDTH - 1);
      out_valid_n = 1'b1;
      done_n      = 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.outp      = outp_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;

`ifdef SERIAL_PATTERN_TX_EXP_HITS_EN
  logic [BW-1:0] hits_c;
  logic [BW-1:0] exp_hits_q;

  pair_count #(.WIDTH(WIDTH)) u_pair_count (
    .w     (bus.inp),
    .count (hits_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_hits_q <= '0;
    end else if (accept) begin
      exp_hits_q <= hits_c;
    end
  end

  assign bus.exp_hits = exp_hits_q;
`endif

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - directed self-checking bench for serial_pattern_tx (WIDTH=8, GAP=1 and GAP=0)
module tb_serial_pattern_tx;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_pattern_tx_if #(.WIDTH(8)) bus1 ();
  serial_pattern_tx_if #(.WIDTH(8)) bus0 ();

  serial_pattern_tx #(.WIDTH(8), .GAP(1)) u_g1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  serial_pattern_tx #(.WIDTH(8), .GAP(0)) u_g0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] w;

    rst           = 1'b0;
    bus1.inp      = '0;
    bus1.in_valid = 1'b0;
    bus0.inp      = '0;
    bus0.in_valid = 1'b0;

    // reset
    step();
    step();
    chk("rst_outp1",      32'(bus1.outp),      32'd0);
    chk("rst_valid1",     32'(bus1.out_valid), 32'd0);
    chk("rst_done1",      32'(bus1.done),      32'd0);
    chk("rst_outp0",      32'(bus0.outp),      32'd0);
    chk("rst_valid0",     32'(bus0.out_valid), 32'd0);
    rst = 1'b1;
    step();
    chk("rel_ready1",     32'(bus1.in_ready),  32'd1);
    chk("rel_ready0",     32'(bus0.in_ready),  32'd1);
    chk("rel_valid1",     32'(bus1.out_valid), 32'd0);

    // single word 11001010, GAP=1
    w = 8'b11001010;
    bus1.inp      = w;
    bus1.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      bus1.in_valid = 1'b0;
      chk("sw_outp",  32'(bus1.outp),      32'(w[7-i]));
      chk("sw_valid", 32'(bus1.out_valid), 32'd1);
      chk("sw_done",  32'(bus1.done),      32'(i == 7));
`ifdef SERIAL_PATTERN_TX_EXP_HITS_EN
      chk("sw_hits",  32'(bus1.exp_hits),  32'd2);
`endif
    end
    step();
    chk("gap_valid",  32'(bus1.out_valid), 32'd0);
    chk("gap_outp",   32'(bus1.outp),      32'd1);
    chk("gap_ready",  32'(bus1.in_ready),  32'd0);
    chk("gap_done",   32'(bus1.done),      32'd0);
    step();
    chk("idle_ready", 32'(bus1.in_ready),  32'd1);
    chk("idle_outp0", 32'(bus1.outp),      32'd0);
    chk("idle_valid", 32'(bus1.out_valid), 32'd0);
    step();
    chk("idle_outp1", 32'(bus1.outp),      32'd1);

    // back-to-back FF then 00, GAP=0
    bus0.inp      = 8'hFF;
    bus0.in_valid = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 1) bus0.inp = 8'h00;
      if (c == 9) bus0.in_valid = 1'b0;
      chk("b2b_valid", 32'(bus0.out_valid), 32'd1);
      chk("b2b_outp",  32'(bus0.outp),      32'(c <= 8));
      chk("b2b_done",  32'(bus0.done),      32'(c == 8 || c == 16));
      if (c == 7) chk("b2b_ready7", 32'(bus0.in_ready), 32'd0);
      if (c == 8) chk("b2b_ready8", 32'(bus0.in_ready), 32'd1);
`ifdef SERIAL_PATTERN_TX_EXP_HITS_EN
      if (c == 1 || c == 9) chk("b2b_hits", 32'(bus0.exp_hits), 32'd7);
`endif
    end
    step();
    chk("b2b_end_valid", 32'(bus0.out_valid), 32'd0);
    chk("b2b_end_outp",  32'(bus0.outp),      32'd1);
    chk("b2b_end_ready", 32'(bus0.in_ready),  32'd1);

    // reset mid-word, word 10100101 on GAP=1 instance
    w = 8'b10100101;
    bus1.inp      = w;
    bus1.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      bus1.in_valid = 1'b0;
      chk("mid_outp", 32'(bus1.outp), 32'(w[7-i]));
    end
    rst = 1'b0;
    step();
    chk("mid_rst_valid", 32'(bus1.out_valid), 32'd0);
    chk("mid_rst_done",  32'(bus1.done),      32'd0);
    chk("mid_rst_outp",  32'(bus1.outp),      32'd0);
    rst = 1'b1;
    step();
    chk("mid_rel_ready", 32'(bus1.in_ready),  32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("mid_no_done",  32'(bus1.done),      32'd0);
      chk("mid_no_valid", 32'(bus1.out_valid), 32'd0);
      step();
    end

    // in_valid held through SHIFT: 00111100 then 10000001
    bus1.inp      = 8'b00111100;
    bus1.in_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) bus1.inp = 8'b10000001;
      chk("ign_valid", 32'(bus1.out_valid), 32'd1);
      chk("ign_done",  32'(bus1.done),      32'(c == 8));
      if (c < 8) chk("ign_ready", 32'(bus1.in_ready), 32'd0);
`ifdef SERIAL_PATTERN_TX_EXP_HITS_EN
      chk("ign_hits1", 32'(bus1.exp_hits), 32'd5);
`endif
    end
    step();
    chk("ign_gap_valid", 32'(bus1.out_valid), 32'd0);
    chk("ign_gap_ready", 32'(bus1.in_ready),  32'd0);
    step();
    chk("ign_idle_valid", 32'(bus1.out_valid), 32'd0);
    chk("ign_idle_ready", 32'(bus1.in_ready),  32'd1);
    w = 8'b10000001;
    for (int c = 0; c < 8; c++) begin
      step();
      bus1.in_valid = 1'b0;
      chk("ign_w2_valid", 32'(bus1.out_valid), 32'd1);
      chk("ign_w2_outp",  32'(bus1.outp),      32'(w[7-c]));
      chk("ign_w2_done",  32'(bus1.done),      32'(c == 7));
    end
    step();
    chk("ign_end_valid", 32'(bus1.out_valid), 32'd0);
    chk("ign_end_outp",  32'(bus1.outp),      32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
